// File: rtl/ofdm_pkg.sv
// rtl/ofdm_pkg.sv - shared OFDM sample format, default sizes and CP read-FSM encoding
//
// Purpose: constants shared by the OFDM transmit-chain blocks.
// Ports:   none (package).
package ofdm_pkg;

  // IFFT sample layout: {4'b0, im[11:0], 4'b0, re[11:0]}
  localparam int RE_LSB = 0;
  localparam int RE_W   = 12;
  localparam int IM_LSB = 16;
  localparam int IM_W   = 12;

  localparam int NFFT_DEF   = 1024;
  localparam int CP_LEN_DEF = 256;

  typedef enum logic [1:0] {
    RD_IDLE = 2'd0,
    RD_CP   = 2'd1,
    RD_BODY = 2'd2
  } cp_rd_state_e;

endpackage

// File: rtl/cp_inserter_if.sv
// rtl/cp_inserter_if.sv - sample stream bundle used on both sides of the CP inserter
//
// Purpose: groups one stream's tdata/tvalid/tready/tlast.
// Ports:   master drives tdata/tvalid/tlast and reads tready;
//          slave reads tdata/tvalid/tlast and drives tready.
interface cp_inserter_if #(
  parameter int DATA_W = 32
);
  logic [DATA_W-1:0] tdata;
  logic              tvalid;
  logic              tready;
  logic              tlast;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/cp_inserter_bank_ram.sv
// rtl/cp_inserter_bank_ram.sv - two-bank frame store, one write port, one synchronous read port
//
// Purpose: 2*NFFT x DATA_W simple dual-port RAM addressed as {bank, index}.
// Ports:   i_clk          clock
//          i_we/i_waddr/i_wdata   write port
//          i_re/i_raddr   read request; o_rdata valid the cycle after i_re
module cp_bank_ram #(
  parameter  int NFFT   = 1024,
  parameter  int DATA_W = 32,
  localparam int AW     = $clog2(NFFT) + 1
) (
  input  logic              i_clk,
  input  logic              i_we,
  input  logic [AW-1:0]     i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_re,
  input  logic [AW-1:0]     i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [2*NFFT];

  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  always_ff @(posedge i_clk) begin
    if (i_re) o_rdata <= r_mem[i_raddr];
  end

endmodule

// File: rtl/cp_inserter.sv
// rtl/cp_inserter.sv - cyclic-prefix insertion with ping-pong frame banks
//
// Purpose: captures NFFT-sample IFFT frames and re-emits each as its last
//          CP_LEN samples followed by all NFFT samples, tlast on the final beat.
// Ports:   aclk, aresetn            clock, async active-low reset
//          s_axis (slave)           IFFT samples in
//          m_axis (master)          CP-extended symbols out
//          err_tlast_missing        pulse: beat NFFT-1 accepted without tlast
//          err_tlast_unexpected     pulse: tlast on any other accepted beat
module cp_inserter
  import ofdm_pkg::*;
#(
  parameter int NFFT   = NFFT_DEF,
  parameter int CP_LEN = CP_LEN_DEF,
  parameter int DATA_W = 32
) (
  input  logic          aclk,
  input  logic          aresetn,
  cp_inserter_if.slave  s_axis,
  cp_inserter_if.master m_axis,
  output logic          err_tlast_missing,
  output logic          err_tlast_unexpected
);

  localparam int AW = $clog2(NFFT);
  localparam int CW = $clog2(NFFT + 1);

  localparam logic [AW-1:0] A_CP_START  = AW'(NFFT - CP_LEN);
  localparam logic [AW-1:0] A_LAST      = AW'(NFFT - 1);
  localparam logic [CW-1:0] C_CP_LAST   = CW'(CP_LEN - 1);
  localparam logic [CW-1:0] C_BODY_LAST = CW'(NFFT - 1);

  if (NFFT < 8 || NFFT > 4096 || (NFFT & (NFFT - 1)) != 0 ||
      CP_LEN < 1 || CP_LEN > NFFT - 1) begin : g_bad_param
    $error("cp_inserter: NFFT must be a power of two in 8..4096 and CP_LEN in 1..NFFT-1");
  end

  // ---------------- write side ----------------
  logic [1:0]    r_full;
  logic          r_wb;
  logic [AW-1:0] r_wcnt;
  logic          w_wr_acc;
  logic          w_wr_close;

  assign s_axis.tready = ~r_full[r_wb];
  assign w_wr_acc      = s_axis.tvalid & ~r_full[r_wb];
  assign w_wr_close    = w_wr_acc & (r_wcnt == A_LAST);

  // The frame always closes on count; tlast only feeds the error pulses.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_wb                 <= 1'b0;
      r_wcnt               <= '0;
      err_tlast_missing    <= 1'b0;
      err_tlast_unexpected <= 1'b0;
    end else begin
      err_tlast_missing    <= w_wr_close & ~s_axis.tlast;
      err_tlast_unexpected <= w_wr_acc & (r_wcnt != A_LAST) & s_axis.tlast;
      if (w_wr_close) begin
        r_wb   <= ~r_wb;
        r_wcnt <= '0;
      end else if (w_wr_acc) begin
        r_wcnt <= r_wcnt + 1'b1;
      end
    end
  end

  // ---------------- read side ----------------
  cp_rd_state_e  r_state;
  logic          r_rb;
  logic [AW-1:0] r_raddr;
  logic [CW-1:0] r_bcnt;

  logic              r_rd_vld;
  logic              r_rd_last;
  logic              r_out_vld;
  logic              r_out_last;
  logic [DATA_W-1:0] r_out_data;
  logic              r_skid_vld;
  logic              r_skid_last;
  logic [DATA_W-1:0] r_skid_data;
  logic [DATA_W-1:0] w_ram_q;

  logic          w_pop;
  logic [1:0]    w_fill;
  logic          w_can_issue;
  logic          w_rd_active;
  logic          w_issue;
  logic          w_in_body;
  logic [AW-1:0] w_rd_idx;
  logic [CW-1:0] w_cnt;
  logic          w_sym_last;
  logic [1:0]    w_full_set;
  logic [1:0]    w_full_clr;

  assign w_pop  = r_out_vld & m_axis.tready;
  // Beats in flight: RAM read stage plus both output slots.
  assign w_fill = 2'(r_out_vld) + 2'(r_skid_vld) + 2'(r_rd_vld);
  // Issue only if the read landing next cycle still has a free slot even
  // when the downstream stalls from then on.
  assign w_can_issue = (w_fill - 2'(w_pop)) <= 2'd1;

  // IDLE with a full bank behaves as the first CP beat so the first read
  // goes out on the cycle right after the frame closes.
  assign w_rd_active = (r_state != RD_IDLE) | r_full[r_rb];
  assign w_issue     = w_rd_active & w_can_issue;
  assign w_in_body   = (r_state == RD_BODY);
  assign w_rd_idx    = (r_state == RD_IDLE) ? A_CP_START : r_raddr;
  assign w_cnt       = (r_state == RD_IDLE) ? '0 : r_bcnt;
  assign w_sym_last  = w_issue & w_in_body & (r_bcnt == C_BODY_LAST);

  // Set and clear never address the same bank, so both apply together.
  assign w_full_set = w_wr_close ? (2'b01 << r_wb) : 2'b00;
  assign w_full_clr = w_sym_last ? (2'b01 << r_rb) : 2'b00;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_full <= 2'b00;
    end else begin
      r_full <= (r_full | w_full_set) & ~w_full_clr;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state <= RD_IDLE;
      r_rb    <= 1'b0;
      r_raddr <= '0;
      r_bcnt  <= '0;
    end else if (w_issue) begin
      if (!w_in_body) begin
        if (w_cnt == C_CP_LAST) begin
          r_state <= RD_BODY;
          r_raddr <= '0;
          r_bcnt  <= '0;
        end else begin
          r_state <= RD_CP;
          r_raddr <= w_rd_idx + 1'b1;
          r_bcnt  <= w_cnt + 1'b1;
        end
      end else if (r_bcnt == C_BODY_LAST) begin
        r_rb <= ~r_rb;
        if (r_full[~r_rb]) begin
          r_state <= RD_CP;
          r_raddr <= A_CP_START;
        end else begin
          r_state <= RD_IDLE;
          r_raddr <= '0;
        end
        r_bcnt <= '0;
      end else begin
        r_raddr <= r_raddr + 1'b1;
        r_bcnt  <= r_bcnt + 1'b1;
      end
    end
  end

  cp_bank_ram #(
    .NFFT   (NFFT),
    .DATA_W (DATA_W)
  ) u_ram (
    .i_clk   (aclk),
    .i_we    (w_wr_acc),
    .i_waddr ({r_wb, r_wcnt}),
    .i_wdata (s_axis.tdata),
    .i_re    (w_issue),
    .i_raddr ({r_rb, w_rd_idx}),
    .o_rdata (w_ram_q)
  );

  // Two-slot output buffer: r_out_* drives the port, r_skid_* catches the
  // read already in flight when the downstream stalls.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_rd_vld    <= 1'b0;
      r_rd_last   <= 1'b0;
      r_out_vld   <= 1'b0;
      r_out_last  <= 1'b0;
      r_out_data  <= '0;
      r_skid_vld  <= 1'b0;
      r_skid_last <= 1'b0;
      r_skid_data <= '0;
    end else begin
      r_rd_vld  <= w_issue;
      r_rd_last <= w_sym_last;
      if (!r_out_vld || w_pop) begin
        if (r_skid_vld) begin
          r_out_vld   <= 1'b1;
          r_out_data  <= r_skid_data;
          r_out_last  <= r_skid_last;
          r_skid_vld  <= r_rd_vld;
          r_skid_data <= w_ram_q;
          r_skid_last <= r_rd_last;
        end else begin
          r_out_vld  <= r_rd_vld;
          r_out_last <= r_rd_vld & r_rd_last;
          if (r_rd_vld) r_out_data <= w_ram_q;
        end
      end else if (r_rd_vld) begin
        r_skid_vld  <= 1'b1;
        r_skid_data <= w_ram_q;
        r_skid_last <= r_rd_last;
      end
    end
  end

  assign m_axis.tdata  = r_out_data;
  assign m_axis.tvalid = r_out_vld;
  assign m_axis.tlast  = r_out_last;

endmodule
